// File: rtl/mmio_mem_window_pkg.sv
// Shared definitions for the MMIO memory window: register offsets,
// status bit positions, FSM states and the offset decoder.
package mmio_mem_window_pkg;

    localparam logic [4:0] OFF_PTR     = 5'h00;
    localparam logic [4:0] OFF_DATA    = 5'h04;
    localparam logic [4:0] OFF_STRIDE  = 5'h08;
    localparam logic [4:0] OFF_FILL    = 5'h0C;
    localparam logic [4:0] OFF_FILLVAL = 5'h10;
    localparam logic [4:0] OFF_STATUS  = 5'h14;

    localparam int STAT_BUSY = 0;
    localparam int STAT_WRAP = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RESP,
        ST_FILL
    } state_t;

    typedef enum logic [2:0] {
        REG_PTR,
        REG_DATA,
        REG_STRIDE,
        REG_FILL,
        REG_FILLVAL,
        REG_STATUS,
        REG_NONE
    } reg_sel_t;

    function automatic reg_sel_t decode_off(
        input logic [4:0] off
    );
        reg_sel_t sel;
        sel = REG_NONE;
        unique case (1'b1)
            (off == OFF_PTR):     sel = REG_PTR;
            (off == OFF_DATA):    sel = REG_DATA;
            (off == OFF_STRIDE):  sel = REG_STRIDE;
            (off == OFF_FILL):    sel = REG_FILL;
            (off == OFF_FILLVAL): sel = REG_FILLVAL;
            (off == OFF_STATUS):  sel = REG_STATUS;
            default:              sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mmio_mem_window_sp_ram_be.sv
// sp_ram_be: single-port word RAM with byte write enables and a
// registered read. Ports: clk, en, we[3:0], addr, wdata, rdata.
module sp_ram_be #(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mmio_mem_window.sv
// mmio_mem_window: picorv32 native-bus register window onto a word RAM
// with a strided pointer and a background block-fill engine.
// Ports: clk, reset (async, active-high); mem_valid/mem_addr/
// mem_wdata/mem_wstrb request; mem_ready/mem_rdata response;
// hit (combinational window decode); busy (fill in progress).
module mmio_mem_window #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0020,
    parameter int          DEPTH     = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic        busy
);
    import mmio_mem_window_pkg::*;

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] STRIDE_RST = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] stride_q;
    logic [AW:0]   fill_cnt_q;
    logic [31:0]   fillval_q;
    logic [31:0]   rdata_q;
    logic          wrap_q;
    logic          stat_rsp_q;

    reg_sel_t      sel;
    logic          is_wr;
    logic          acc_idle;
    logic          acc_stat;
    logic          data_rd;
    logic          data_wr;
    logic          fill_wr;
    logic          ptr_step;
    logic [AW:0]   ptr_sum;
    logic [31:0]   status;
    logic [31:0]   rd_val;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Base is 32-byte aligned, so the window is one 32-byte block.
    assign hit   = mem_valid
                && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign sel   = decode_off(mem_addr[4:0]);
    assign is_wr = |mem_wstrb;

    // mem_ready gating keeps a held request from being taken twice.
    assign acc_idle = hit && (state_q == ST_IDLE) && !mem_ready;

    // Only STATUS reads bypass the fill stall.
    assign acc_stat = hit && (state_q == ST_FILL) && !is_wr
                   && (sel == REG_STATUS) && !stat_rsp_q;

    assign data_rd  = acc_idle && (sel == REG_DATA) && !is_wr;
    assign data_wr  = acc_idle && (sel == REG_DATA) && is_wr;
    assign fill_wr  = (state_q == ST_FILL);
    assign ptr_step = data_rd || data_wr || fill_wr;

    // Carry out of the AW-bit sum is the wrap indication.
    assign ptr_sum  = {1'b0, ptr_q} + {1'b0, stride_q};

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_WRAP] = wrap_q;
    end

    always_comb begin
        rd_val = '0;
        unique case (sel)
            REG_PTR:     rd_val = 32'(ptr_q);
            REG_STRIDE:  rd_val = 32'(stride_q);
            REG_FILLVAL: rd_val = fillval_q;
            REG_STATUS:  rd_val = status;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc_idle) begin
                    state_d = data_rd ? ST_RD_WAIT : ST_RESP;
                end
            end
            ST_RD_WAIT: state_d = ST_RESP;
            ST_RESP: begin
                // A nonzero count is only ever loaded by a FILL write.
                state_d = (fill_cnt_q != '0) ? ST_FILL : ST_IDLE;
            end
            ST_FILL: begin
                if (fill_cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_FILL);
        mem_ready = (state_q == ST_RESP) || stat_rsp_q;
        mem_rdata = mem_ready ? rdata_q : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            stride_q   <= STRIDE_RST;
            fillval_q  <= '0;
            fill_cnt_q <= '0;
            wrap_q     <= 1'b0;
            stat_rsp_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            stat_rsp_q <= acc_stat;

            if (ptr_step) begin
                ptr_q <= ptr_sum[AW-1:0];
                if (ptr_sum[AW]) begin
                    wrap_q <= 1'b1;
                end
            end

            if (fill_wr) begin
                fill_cnt_q <= fill_cnt_q - CNT_ONE;
            end

            if (acc_stat) begin
                rdata_q <= status;
            end else if (state_q == ST_RD_WAIT) begin
                rdata_q <= ram_rdata;
            end else if (acc_idle) begin
                rdata_q <= is_wr ? '0 : rd_val;
            end

            if (acc_idle && is_wr) begin
                unique case (sel)
                    REG_PTR:     ptr_q      <= mem_wdata[AW-1:0];
                    REG_STRIDE:  stride_q   <= mem_wdata[AW-1:0];
                    REG_FILL:    fill_cnt_q <= mem_wdata[AW:0];
                    REG_FILLVAL: fillval_q  <= mem_wdata;
                    REG_STATUS: begin
                        if (mem_wdata[STAT_WRAP]) begin
                            wrap_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ram_en    = ptr_step;
        ram_we    = 4'h0;
        ram_wdata = mem_wdata;
        if (fill_wr) begin
            ram_we    = 4'hF;
            ram_wdata = fillval_q;
        end else if (data_wr) begin
            ram_we = mem_wstrb;
        end
    end

    sp_ram_be #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ptr_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mmio_mem_window.sv
// Bench for mmio_mem_window: vector table plus hand sequences,
// expected responses queued on drive and compared on mem_ready.
module tb_mmio_mem_window;

    localparam logic [31:0] BASE  = 32'h1000_0020;
    localparam int          DEPTH = 16384;

    localparam logic [4:0] O_PTR = 5'h00;
    localparam logic [4:0] O_DAT = 5'h04;
    localparam logic [4:0] O_STR = 5'h08;
    localparam logic [4:0] O_FIL = 5'h0C;
    localparam logic [4:0] O_FVL = 5'h10;
    localparam logic [4:0] O_STA = 5'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        busy;

    always #5 clk = ~clk;

    mmio_mem_window #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .hit       (hit),
        .busy      (busy)
    );

    typedef struct {
        string       name;
        logic [4:0]  off;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk;
        logic [31:0] exp;
        int          lat;
    } exp_t;

    vec_t tv[$];
    exp_t sbq[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic last_busy;
    int   bcnt;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm,
                                input logic [4:0] off,
                                input logic [31:0] wd,
                                input logic [3:0] ws,
                                input logic [31:0] exp,
                                input int lat);
        vec_t v;
        v.name = nm;
        v.off  = off;
        v.wd   = wd;
        v.ws   = ws;
        v.exp  = exp;
        v.lat  = lat;
        return v;
    endfunction

    function automatic vec_t W(input string nm,
                               input logic [4:0] off,
                               input logic [31:0] wd);
        return mk(nm, off, wd, 4'hF, 32'h0, 1);
    endfunction

    function automatic vec_t R(input string nm,
                               input logic [4:0] off,
                               input logic [31:0] exp,
                               input int lat);
        return mk(nm, off, 32'h0, 4'h0, exp, lat);
    endfunction

    task automatic txn(input string nm,
                       input logic [4:0] off,
                       input logic [31:0] wd,
                       input logic [3:0] ws,
                       input logic [31:0] exp_rd,
                       input int exp_lat);
        exp_t e;
        exp_t p;
        logic got;
        int   lat;
        e.name = nm;
        e.chk  = (ws == 4'h0);
        e.exp  = exp_rd;
        e.lat  = exp_lat;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = BASE + {27'b0, off};
        mem_wdata = wd;
        mem_wstrb = ws;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        check({nm, ".hit"}, {31'b0, hit}, 32'd1);
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mem_ready) begin
                got = 1'b1;
            end else begin
                check({nm, ".rdz"}, mem_rdata, 32'h0);
            end
        end
        p = sbq.pop_front();
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: no ready after %0d cycles",
                     p.name, lat);
        end else begin
            check({p.name, ".lat"}, lat, p.lat);
            if (p.chk) begin
                check({p.name, ".rd"}, mem_rdata, p.exp);
            end
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        check({p.name, ".single"}, {31'b0, mem_ready}, 32'd0);
        last_busy = busy;
    endtask

    task automatic wr(input string nm,
                      input logic [4:0] off,
                      input logic [31:0] wd);
        txn(nm, off, wd, 4'hF, 32'h0, 1);
    endtask

    task automatic rd(input string nm,
                      input logic [4:0] off,
                      input logic [31:0] exp,
                      input int lat);
        txn(nm, off, 32'h0, 4'h0, exp, lat);
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;

        tv.push_back(R("rst_ptr", O_PTR, 32'd0, 1));
        tv.push_back(R("rst_stride", O_STR, 32'd1, 1));
        tv.push_back(R("rst_fillval", O_FVL, 32'd0, 1));
        tv.push_back(R("rst_status", O_STA, 32'd0, 1));
        tv.push_back(W("seq_ptr5", O_PTR, 32'd5));
        tv.push_back(W("seq_str1", O_STR, 32'd1));
        tv.push_back(W("seq_wa", O_DAT, 32'hA));
        tv.push_back(W("seq_wb", O_DAT, 32'hB));
        tv.push_back(W("seq_ptr5b", O_PTR, 32'd5));
        tv.push_back(R("seq_ra", O_DAT, 32'hA, 2));
        tv.push_back(R("seq_rb", O_DAT, 32'hB, 2));
        tv.push_back(R("seq_ptr7", O_PTR, 32'd7, 1));
        tv.push_back(W("be_ptr", O_PTR, 32'd20));
        tv.push_back(W("be_ones", O_DAT, 32'hFFFF_FFFF));
        tv.push_back(W("be_ptr2", O_PTR, 32'd20));
        tv.push_back(mk("be_w", O_DAT, 32'h1122_3344,
                        4'b0010, 32'h0, 1));
        tv.push_back(W("be_ptr3", O_PTR, 32'd20));
        tv.push_back(R("be_rd", O_DAT, 32'hFFFF_33FF, 2));
        tv.push_back(R("be_ptr21", O_PTR, 32'd21, 1));
        tv.push_back(R("rsv18_rd", 5'h18, 32'd0, 1));
        tv.push_back(W("rsv1c_wr", 5'h1C, 32'hFFFF_FFFF));
        tv.push_back(R("rsv1c_rd", 5'h1C, 32'd0, 1));
        tv.push_back(W("wrap_ptr", O_PTR, DEPTH - 1));
        tv.push_back(W("wrap_str", O_STR, 32'd2));
        tv.push_back(W("wrap_w", O_DAT, 32'h77));
        tv.push_back(R("wrap_ptr1", O_PTR, 32'd1, 1));
        tv.push_back(R("wrap_st2", O_STA, 32'h2, 1));
        tv.push_back(W("wrap_clr", O_STA, 32'h2));
        tv.push_back(R("wrap_st0", O_STA, 32'h0, 1));
        tv.push_back(W("s0_str", O_STR, 32'd0));
        tv.push_back(W("s0_ptr", O_PTR, 32'd30));
        tv.push_back(W("s0_w1", O_DAT, 32'h55));
        tv.push_back(W("s0_w2", O_DAT, 32'h66));
        tv.push_back(R("s0_rd", O_DAT, 32'h66, 2));
        tv.push_back(R("s0_ptr", O_PTR, 32'd30, 1));
        tv.push_back(W("s0_str1", O_STR, 32'd1));
        tv.push_back(W("fv_wr", O_FVL, 32'h0000_1234));
        tv.push_back(R("fv_rd", O_FVL, 32'h0000_1234, 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.ready", {31'b0, mem_ready}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.rdata", mem_rdata, 32'h0);

        foreach (tv[i]) begin
            txn(tv[i].name, tv[i].off, tv[i].wd, tv[i].ws,
                tv[i].exp, tv[i].lat);
        end

        // Fill of 4 words; word 4 must survive.
        wr("f4_ptr4", O_PTR, 32'd4);
        wr("f4_mark", O_DAT, 32'h1234_5678);
        wr("f4_fv", O_FVL, 32'hDEAD_BEEF);
        wr("f4_ptr0", O_PTR, 32'd0);
        wr("f4_str", O_STR, 32'd1);
        wr("f4_go", O_FIL, 32'd4);
        bcnt = int'(last_busy);
        repeat (20) begin
            @(negedge clk);
            bcnt += int'(busy);
        end
        check("f4.busy_cycles", bcnt, 32'd4);
        wr("f4_rptr", O_PTR, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd("f4_word", O_DAT, 32'hDEAD_BEEF, 2);
        end
        rd("f4_word4", O_DAT, 32'h1234_5678, 2);

        // Zero-length fill: no busy at all.
        wr("f0_go", O_FIL, 32'd0);
        bcnt = int'(last_busy);
        repeat (6) begin
            @(negedge clk);
            bcnt += int'(busy);
        end
        check("f0.busy_cycles", bcnt, 32'd0);

        // Requests during a fill of 8 at stride 0.
        wr("f8_fv", O_FVL, 32'hCAFE_0001);
        wr("f8_str", O_STR, 32'd0);
        wr("f8_ptr", O_PTR, 32'd100);
        wr("f8_go", O_FIL, 32'd8);
        rd("f8_status", O_STA, 32'h1, 1);
        rd("f8_stall", O_DAT, 32'hCAFE_0001, 6);
        wr("f8_str1", O_STR, 32'd1);

        // Out-of-window requests are ignored.
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_wstrb = 4'h0;
        mem_addr  = BASE - 32'd4;
        repeat (3) begin
            @(negedge clk);
            check("miss_lo.hit", {31'b0, hit}, 32'd0);
            check("miss_lo.rdy", {31'b0, mem_ready}, 32'd0);
        end
        mem_addr = BASE + 32'd32;
        repeat (3) begin
            @(negedge clk);
            check("miss_hi.hit", {31'b0, hit}, 32'd0);
            check("miss_hi.rdy", {31'b0, mem_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;

        // Reset during the 3rd cycle of a fill of 10.
        wr("rf_ptr", O_PTR, 32'd40);
        for (int i = 0; i < 4; i++) begin
            wr("rf_clr", O_DAT, 32'h0);
        end
        wr("rf_fv", O_FVL, 32'h5A5A_5A5A);
        wr("rf_ptr2", O_PTR, 32'd40);
        wr("rf_go", O_FIL, 32'd10);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("rf.busy", {31'b0, busy}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("rf.busy_hold", {31'b0, busy}, 32'd0);
        end
        rd("rf_ptr0", O_PTR, 32'd0, 1);
        rd("rf_status", O_STA, 32'h0, 1);
        wr("rf_ptr40", O_PTR, 32'd40);
        rd("rf_w40", O_DAT, 32'h5A5A_5A5A, 2);
        rd("rf_w41", O_DAT, 32'h5A5A_5A5A, 2);
        rd("rf_w42", O_DAT, 32'h0, 2);
        rd("rf_w43", O_DAT, 32'h0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_mem_window.md
MMIO_MEM_WINDOW -- requirements
Module: mmio_mem_window

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0020, SHALL be the byte base of the register window and be 32-byte aligned.
REQ-002 Parameter DEPTH, default 16384, SHALL be the backing RAM size in 32-bit words, a power of two; AW = clog2(DEPTH) is derived.
REQ-003 Port clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port mem_valid  input  1  SHALL be the picorv32 native-bus request strobe.
REQ-006 Port mem_addr  input  32  SHALL be the request byte address.
REQ-007 Port mem_wdata  input  32  SHALL be the write data.
REQ-008 Port mem_wstrb  input  4  SHALL be the byte strobes; 0 means read.
REQ-009 Port mem_ready  output  1  SHALL be the one-cycle completion pulse.
REQ-010 Port mem_rdata  output  32  SHALL be the read data, valid while mem_ready=1.
REQ-011 Port hit  output  1  SHALL be a combinational decode: mem_valid and mem_addr in [BASE_ADDR, BASE_ADDR+0x20).
REQ-012 Port busy  output  1  SHALL be high while a fill is running.

Function
REQ-013 Register offsets SHALL be: 0x00 PTR (word index, AW bits), 0x04 DATA, 0x08 STRIDE (AW bits), 0x0C FILL (write-only count, AW+1 bits), 0x10 FILLVAL, 0x14 STATUS. Other offsets in the window read 0, ignore writes, and complete in 1 cycle.
REQ-014 The FSM SHALL have the states IDLE, RD_WAIT, RESP and FILL. Requests are accepted only in IDLE, with hit=1 and mem_ready=0.
REQ-015 Writes to PTR, STRIDE, FILLVAL and STATUS, and any register read except DATA, SHALL go IDLE->RESP; mem_ready is high the cycle after acceptance (latency 1).
REQ-016 A DATA write SHALL write RAM[PTR] with per-byte mem_wstrb, then set PTR <= (PTR+STRIDE) mod DEPTH; latency 1.
REQ-017 A DATA read SHALL go IDLE->RD_WAIT->RESP, with mem_ready and RAM[PTR] on mem_rdata 2 cycles after acceptance; PTR then advances by STRIDE.
REQ-018 STRIDE=0 SHALL leave PTR unchanged (repeated access to one word).
REQ-019 When PTR+STRIDE >= DEPTH, STATUS[1] (WRAP) SHALL be set sticky; writing STATUS with wdata[1]=1 clears it.
REQ-020 A FILL write with count N>0 SHALL complete the bus access (latency 1), then enter FILL. In FILL, one word of FILLVAL is written per cycle at PTR, PTR advances by STRIDE, and FILL exits to IDLE after exactly N writes.
REQ-021 A FILL write with N=0 SHALL complete with no RAM write and no busy pulse.
REQ-022 busy and STATUS[0] SHALL be 1 from the cycle after the FILL response through the last fill write.
REQ-023 During FILL, a STATUS read SHALL be served with latency 1. Every other hit request SHALL be stalled (mem_ready held 0) until FILL ends, then be processed normally.
REQ-024 mem_rdata SHALL be 0 whenever mem_ready=0.
REQ-025 mem_ready SHALL never be high for two consecutive cycles.
REQ-026 Requests with hit=0 SHALL be ignored and SHALL produce no mem_ready.

Reset
REQ-027 On reset, the block SHALL set: state IDLE, PTR=0, STRIDE=1, FILLVAL=0, fill count=0, WRAP=0, mem_ready=0, mem_rdata=0, busy=0. RAM contents are not reset.
REQ-028 Reset asserted mid-fill or mid-read SHALL abort immediately, with no further RAM writes after deassertion.

Structure
REQ-029 A shared package SHALL hold the register offset constants and the FSM state enumeration.
REQ-030 The RAM SHALL be a sub-module sp_ram_be: single-port, byte-enable, registered read, parametrised on DEPTH.

Verification
REQ-031 Set PTR=5, STRIDE=1. DATA writes 0xA,0xB, then PTR=5, then 2 DATA reads -> 0xA,0xB, each with mem_ready 2 cycles after valid; PTR reads 7.
REQ-032 PTR=DEPTH-1, STRIDE=2, DATA write -> PTR reads 1 and STATUS=0x2. STATUS write 0x2 -> STATUS reads 0.
REQ-033 FILLVAL=0xDEADBEEF, PTR=0, STRIDE=1, FILL=4 -> busy high for 4 cycles; words 0..3 = 0xDEADBEEF, word 4 unchanged.
REQ-034 A DATA read issued during a FILL of 8 -> stalled until busy falls, then returns the fill value; a STATUS read during the fill returns 0x1 with latency 1.
REQ-035 DATA write 0x11223344 with wstrb=4'b0010 over 0xFFFFFFFF -> word reads 0xFFFF33FF. A FILL=0 write -> busy stays 0.
REQ-036 Reset pulsed on the 3rd cycle of a FILL of 10 -> after release, busy=0, PTR=0, and exactly 2 words written.
